// File: rtl/audio_dc_filter.sv
// DC-blocking high-pass filter with serial volume multiply and output
// saturation. Sits between the sound block and the audio output. One sample
// is accepted per in_valid strobe while idle. The result appears 10 cycles
// after capture.
//
// state | meaning
// IDLE  | waiting for in_valid; captures sample, volume and mute
// FILT  | one-pole high-pass update, clamp y into the 16-bit multiplicand
// MUL   | 8-cycle LSB-first shift-add of y by the captured volume
// SAT   | result presented with out_valid; returns to IDLE
module audio_dc_filter #(
   parameter int LEAK_SHIFT = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] audio_in,
   input  logic [7:0]  vol,
   input  logic        mute,
   output logic [15:0] audio_out,
   output logic        out_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int AW = 18 + LEAK_SHIFT;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILT = 2'd1;
   localparam logic [1:0] MUL  = 2'd2;
   localparam logic [1:0] SAT  = 2'd3;

   localparam logic signed [AW-1:0] Y_MAX = AW'(32'sd32767);
   localparam logic signed [AW-1:0] Y_MIN = AW'(-32'sd32768);
   localparam logic signed [24:0]   P_MAX = 25'sd32767;
   localparam logic signed [24:0]   P_MIN = -25'sd32768;

   logic [1:0]           state;
   logic signed [15:0]   x_cur;
   logic signed [15:0]   x_prev;
   logic [7:0]           vol_l;
   logic                 mute_l;
   logic signed [AW-1:0] y_acc;
   logic signed [15:0]   mcand;
   logic signed [24:0]   product;
   logic [2:0]           cnt;

   logic signed [AW-1:0] x_ext;
   logic signed [AW-1:0] xp_ext;
   logic signed [AW-1:0] diff_ext;
   logic signed [AW-1:0] y_acc_new;
   logic signed [AW-1:0] y_full;
   logic signed [15:0]   y_sat;
   logic signed [24:0]   mcand_ext;
   logic signed [24:0]   addend;
   logic signed [24:0]   product_next;
   logic signed [24:0]   r_full;
   logic signed [15:0]   r_sat;

   assign busy = (state != IDLE);

   // High-pass update: y_acc carries y scaled by 2^LEAK_SHIFT, so the leak is
   // a single arithmetic right shift of the accumulator.
   always_comb begin
      x_ext     = {{(AW-16){x_cur[15]}}, x_cur};
      xp_ext    = {{(AW-16){x_prev[15]}}, x_prev};
      diff_ext  = x_ext - xp_ext;
      y_acc_new = (diff_ext <<< LEAK_SHIFT) + y_acc - (y_acc >>> LEAK_SHIFT);
      y_full    = y_acc_new >>> LEAK_SHIFT;
      y_sat     = y_full[15:0];
      if (y_full > Y_MAX)
         y_sat = 16'sh7fff;
      else if (y_full < Y_MIN)
         y_sat = -16'sh8000;
   end

   // One shift-add step plus the clamped output of the resulting product.
   always_comb begin
      mcand_ext    = {{9{mcand[15]}}, mcand};
      addend       = vol_l[cnt] ? (mcand_ext <<< cnt) : 25'sd0;
      product_next = product + addend;
      r_full       = product_next >>> 7;
      r_sat        = r_full[15:0];
      if (r_full > P_MAX)
         r_sat = 16'sh7fff;
      else if (r_full < P_MIN)
         r_sat = -16'sh8000;
   end

   // Sequencer and datapath registers. The output register is loaded on the
   // edge that closes the last MUL step, so audio_out is already valid during
   // the SAT cycle in which out_valid is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         x_cur     <= '0;
         x_prev    <= '0;
         vol_l     <= '0;
         mute_l    <= 1'b0;
         y_acc     <= '0;
         mcand     <= '0;
         product   <= '0;
         cnt       <= '0;
         audio_out <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid && (state != IDLE))
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_cur  <= audio_in ^ 16'h8000;
                  vol_l  <= vol;
                  mute_l <= mute;
                  state  <= FILT;
               end
            end
            FILT: begin
               y_acc   <= y_acc_new;
               x_prev  <= x_cur;
               mcand   <= y_sat;
               product <= '0;
               cnt     <= '0;
               state   <= MUL;
            end
            MUL: begin
               product <= product_next;
               cnt     <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  audio_out <= mute_l ? 16'h0000 : r_sat;
                  out_valid <= 1'b1;
                  state     <= SAT;
               end
            end
            SAT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/audio_dc_filter.md
Name: audio_dc_filter

Overview:
- Post-processing stage directly downstream of the sound block. Consumes its 16-bit unsigned mixed audio once per 12 kHz sample strobe.
- Removes DC offset with a shift-based first-order high-pass filter.
- Applies an 8-bit volume through a serial shift-add multiplier, then saturates.
- Delivers signed 16-bit samples with a valid pulse to the MiSTer audio output.

Parameters:
- LEAK_SHIFT, 10: filter pole a = 1 - 2^-LEAK_SHIFT; legal range 4..14.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 clears all state.
- in_valid  in  1  one-clk strobe: audio_in holds a new sample (driven from clk_12KHz_en).
- audio_in  in  16  unsigned offset-binary sample from the sound block.
- vol  in  8  gain; out = y*vol/128 (128 = unity, 255 ≈ +6 dB, 0 = silence).
- mute  in  1  forces output samples to 0; filter state keeps updating.
- audio_out  out  16  signed filtered/scaled sample; held between updates.
- out_valid  out  1  one-clk pulse when audio_out updates.
- busy  out  1  high while a sample is in flight (not IDLE).
- overrun  out  1  sticky; set when in_valid arrives while busy; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; audio_out=0; out_valid=0; busy=0; overrun=0; x_prev=0; y_acc=0; product=0.
- Input conversion: x = audio_in XOR 16'h8000, signed.
- y_acc: signed, 18+LEAK_SHIFT bits, holds y*2^LEAK_SHIFT.
- IDLE:
  - On in_valid: latch x, vol, mute.
  - Enter FILT next cycle; busy=1 from that cycle.
- FILT (1 cycle):
  - y_acc <= ((x - x_prev) <<< LEAK_SHIFT) + y_acc - (y_acc >>> LEAK_SHIFT), arithmetic shifts, full width, no overflow possible.
  - x_prev <= x.
  - y = y_acc_new >>> LEAK_SHIFT, saturated to [-32768, 32767] to form the 16-bit multiplicand.
- MUL (8 cycles):
  - Serial shift-add of the 16-bit signed y by the 8-bit unsigned latched vol, LSB first, into a 25-bit signed product cleared on entry.
  - Iteration counter 0..7.
- SAT (1 cycle):
  - r = product >>> 7, saturated to [-32768, 32767].
  - audio_out <= latched mute ? 0 : r.
  - out_valid=1 for this cycle only.
  - Return to IDLE; busy=0 the following cycle.
- Latency: in_valid sampled at edge N → out_valid high during cycle N+10 (1 FILT + 8 MUL + 1 SAT after capture). Throughput 1 sample per 11 clk; at 12 kHz it is never limited.
- Inputs while busy:
  - in_valid while busy is dropped and sets overrun. Filter state is unaffected by dropped samples.
  - vol/mute changes mid-sample have no effect until the next capture.
- in_valid in the same cycle SAT completes: busy is still 1 → dropped. A sample is accepted only in IDLE.
- Saturation is symmetric: the clamp applies at both the y stage and the output stage.
- Reset mid-operation: immediate return to IDLE with all state cleared; no out_valid is emitted for the aborted sample.
- Steady DC input: output decays toward 0 with time constant about 2^LEAK_SHIFT samples.

Test Plan:
- Step, unity gain: reset; samples 0x8000, 0x8000, then 0x9000, vol=128, LEAK_SHIFT=10.
  - Outputs 0, 0, then 4096.
  - Next 0x9000 sample → 4092; subsequent outputs monotonically decrease toward 0.
- Latency/handshake: single in_valid at cycle N.
  - busy rises at N+1; out_valid is exactly one pulse at N+10; busy falls at N+11.
  - No second pulse.
- Saturation:
  - 0x0000 then 0xFFFF, vol=255 → second output 32767.
  - Then 0x0000 → -32768.
  - vol=0 on any sample → 0.
- Gain: DC-settled filter, then step of +1000 LSB.
  - vol=64 → 500.
  - vol=192 on an identical fresh step → 1500.
- Overrun and mute:
  - Second in_valid 3 cycles after the first → overrun=1; only one out_valid; x_prev equals the first sample.
  - mute=1 → audio_out=0 but next unmuted output reflects the continued filter state.
- Reset mid-MUL: assert rst at cycle N+5.
  - All outputs 0 immediately; no out_valid.
  - After release, 0x9000 from 0x8000 history (x_prev=0) → 4096.
